multicycle_controller: RTL

//  Control FSM for the RV32I multicycle datapath. Decodes op/funct fields of the latched instruction.

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the RV32I multicycle controller and its datapath.
// The controller takes the master view. The datapath (or a bench) takes the slave view.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Mem_Ready;
    logic       PC_Write;
    logic       Adr_Src;
    logic       Mem_Write;
    logic       IR_Write;
    logic       Reg_Write;
    logic [1:0] Result_Src;
    logic [1:0] ALU_SrcA;
    logic [1:0] ALU_SrcB;
    logic [2:0] ALU_Control;
    logic [2:0] Imm_Src;

    modport master (
        input  op, funct3, funct7b5, Zero, Mem_Ready,
        output PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write,
               Result_Src, ALU_SrcA, ALU_SrcB, ALU_Control, Imm_Src
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Mem_Ready,
        input  PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write,
               Result_Src, ALU_SrcA, ALU_SrcB, ALU_Control, Imm_Src
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM. It sequences fetch, decode, execute, memory and writeback.
// It drives every datapath select and write enable from the current state and the latched instruction.
// While rst_n is low, the write enables are held low combinationally.
// As a result, an access in flight is cut off without waiting for a clock edge.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
    logic [2:0] alu_control_c, imm_src_c;

    // Only R-type uses funct7b5. Without it, addi with imm[10]=1 would become a subtract.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r,
                                              input logic f7b5);
        case (f3)
            3'b000:  alu_decode = (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b100:  alu_decode = 3'b100;
            3'b110:  alu_decode = 3'b011;
            3'b111:  alu_decode = 3'b010;
            3'b010:  alu_decode = 3'b101;
            default: alu_decode = 3'b000;
        endcase
    endfunction

    assign mem_rdy = MEM_HANDSHAKE ? bus.Mem_Ready : 1'b1;

    // State register; reset lands in FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and output decode; defaults are the FETCH selects with all enables off.
    always_comb begin
        state_d       = S_FETCH;
        pc_write_c    = 1'b0;
        adr_src_c     = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        result_src_c  = 2'b10;
        alu_src_a_c   = 2'b00;
        alu_src_b_c   = 2'b10;
        alu_control_c = 3'b000;
        imm_src_c     = 3'b000;
        case (state_q)
            S_FETCH: begin
                ir_write_c = mem_rdy;
                pc_write_c = mem_rdy;
                state_d    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm as the branch/jump target.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.op == OP_JAL) ? 3'b100 : 3'b010;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.op == OP_SW) ? 3'b001 : 3'b000;
                state_d     = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c    = 1'b1;
                result_src_c = 2'b00;
                state_d      = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up until the memory acknowledges.
                adr_src_c    = 1'b1;
                result_src_c = 2'b00;
                mem_write_c  = 1'b1;
                state_d      = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a_c   = 2'b10;
                alu_src_b_c   = 2'b00;
                alu_control_c = alu_decode(bus.funct3, 1'b1, bus.funct7b5);
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c   = 2'b10;
                alu_src_b_c   = 2'b01;
                alu_control_c = alu_decode(bus.funct3, 1'b0, bus.funct7b5);
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = 2'b00;
                reg_write_c  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c   = 2'b10;
                alu_src_b_c   = 2'b00;
                alu_control_c = 3'b001;
                result_src_c  = 2'b00;
                pc_write_c    = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                                ((bus.funct3 == 3'b001) && !bus.Zero);
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd.
                alu_src_a_c  = 2'b01;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b00;
                pc_write_c   = 1'b1;
                state_d      = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_c = 2'b11;
                alu_src_b_c = 2'b01;
                imm_src_c   = 3'b011;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.PC_Write    = pc_write_c  & rst_n;
    assign bus.Mem_Write   = mem_write_c & rst_n;
    assign bus.IR_Write    = ir_write_c  & rst_n;
    assign bus.Reg_Write   = reg_write_c & rst_n;
    assign bus.Adr_Src     = adr_src_c;
    assign bus.Result_Src  = result_src_c;
    assign bus.ALU_SrcA    = alu_src_a_c;
    assign bus.ALU_SrcB    = alu_src_b_c;
    assign bus.ALU_Control = alu_control_c;
    assign bus.Imm_Src     = imm_src_c;

endmodule
